// File: rtl/pc_sequencer_if.sv
// Bus between the instruction decoder/datapath side and the PC sequencer.
// The sequencer drives the PC, the commit strobe, the link write and the
// OutR valid; the environment drives the strobes, flags and out_ready.
`timescale 1ns/1ps
interface pc_sequencer_if #(
  parameter int PC_W = 16
);
  logic            start;
  logic [15:0]     instr;
  logic            bcc, bcs, bne, beq, bal;
  logic            jmp, jal_label, jal_rm, jr, hlt, outr;
  logic            flag_c, flag_z;
  logic [15:0]     rm_data;
  logic            out_ready;

  logic [PC_W-1:0] pc;
  logic            commit;
  logic            link_we;
  logic [15:0]     link_data;
  logic            out_valid;
  logic            halted;

  // Sequencer side: owns the PC and the OutR valid.
  modport master (
    input  start, instr,
    input  bcc, bcs, bne, beq, bal,
    input  jmp, jal_label, jal_rm, jr, hlt, outr,
    input  flag_c, flag_z, rm_data, out_ready,
    output pc, commit, link_we, link_data, out_valid, halted
  );

  // Decoder/datapath/sink side.
  modport slave (
    output start, instr,
    output bcc, bcs, bne, beq, bal,
    output jmp, jal_label, jal_rm, jr, hlt, outr,
    output flag_c, flag_z, rm_data, out_ready,
    input  pc, commit, link_we, link_data, out_valid, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and run-control sequencer for the 16-bit single-cycle CPU.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | pc parked at RESET_PC, nothing commits, waiting for start
//   RUN      | one instruction commits per clock (except an OutR stall)
//   OUT_WAIT | OutR value presented, waiting for out_ready, pc held
//   HALT     | HLT retired, pc held, only rst leaves
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_OUT_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [PC_W-1:0] pc_plus1;
  logic [15:0]     off8_16;
  logic [15:0]     off11_16;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] next_pc;

  logic            commit;
  logic            out_valid;

  // Upper instruction bits and (for narrow PCs) upper rm_data bits are not
  // needed for target computation.
  logic            unused_bits;
  assign unused_bits = ^{bus.instr[15:11], bus.rm_data};

  assign pc_plus1   = pc_q + PC_W'(1);
  assign off8_16    = {{8{bus.instr[7]}}, bus.instr[7:0]};
  assign off11_16   = {{5{bus.instr[10]}}, bus.instr[10:0]};
  assign br_target  = pc_plus1 + off8_16[PC_W-1:0];
  assign jmp_target = pc_plus1 + off11_16[PC_W-1:0];

  // Target selection for a committing instruction, in strobe priority order.
  // HLT keeps the pc; OutR always falls through to pc+1.
  always_comb begin
    next_pc = pc_plus1;
    if (bus.hlt)            next_pc = pc_q;
    else if (bus.outr)      next_pc = pc_plus1;
    else if (bus.jr)        next_pc = bus.rm_data[PC_W-1:0];
    else if (bus.jal_rm)    next_pc = bus.rm_data[PC_W-1:0];
    else if (bus.jal_label) next_pc = jmp_target;
    else if (bus.jmp)       next_pc = jmp_target;
    else if (bus.bal)       next_pc = br_target;
    else if (bus.beq)       next_pc = bus.flag_z  ? br_target : pc_plus1;
    else if (bus.bne)       next_pc = !bus.flag_z ? br_target : pc_plus1;
    else if (bus.bcs)       next_pc = bus.flag_c  ? br_target : pc_plus1;
    else if (bus.bcc)       next_pc = !bus.flag_c ? br_target : pc_plus1;
  end

  // State and pc registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-pc and handshake outputs. out_valid depends only on
  // state and the OutR strobe, never on out_ready.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    commit    = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pc_d = RESET_PC;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.hlt) begin
          commit  = 1'b1;
          state_d = S_HALT;
        end else if (bus.outr) begin
          out_valid = 1'b1;
          if (bus.out_ready) begin
            commit = 1'b1;
            pc_d   = pc_plus1;
          end else begin
            state_d = S_OUT_WAIT;
          end
        end else begin
          commit = 1'b1;
          pc_d   = next_pc;
        end
      end
      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          commit  = 1'b1;
          pc_d    = pc_plus1;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.commit    = commit;
  assign bus.out_valid = out_valid;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.link_we   = commit & (bus.jal_label | bus.jal_rm);
  assign bus.link_data = 16'(pc_plus1);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control sequencer for the 16-bit single-cycle CPU. It consumes the one-hot instruction-class strobes from the instruction decoder plus the ALU carry/zero flags. It produces the program counter, a per-instruction commit strobe, the JAL link write and the OutR output handshake. It also owns the idle/run/halt lifecycle of the core.

## Interface
- PC_W, 16, program counter width (word addressed, ≤16)
- RESET_PC, 0, PC value loaded on reset and held in IDLE

- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- start  in  1  leave IDLE and begin execution; ignored in every other state
- instr  in  16  instruction currently fetched at pc
- bcc, bcs, bne, beq, bal  in  1 each  decoded conditional/always branch strobes
- jmp, jal_label, jal_rm, jr, hlt, outr  in  1 each  decoded jump/halt/output strobes
- flag_c, flag_z  in  1  carry/zero flags as last written by the datapath
- rm_data  in  16  register-file read of Rm, used by JAL Rm and JR
- out_ready  in  1  output sink accepts the OutR value
- pc  out  PC_W  address of the current instruction
- commit  out  1  current instruction retires this cycle; datapath register/memory/flag writes are gated by it
- link_we  out  1  write link_data into R7
- link_data  out  16  pc+1, zero-extended
- out_valid  out  1  OutR value is presented to the sink
- halted  out  1  core is in HALT

## Operation
- State machine: IDLE, RUN, OUT_WAIT, HALT.
  - IDLE: pc=RESET_PC, commit=0. start=1 moves to RUN.
  - RUN: commit=1 unless an OutR stall applies. pc loads next_pc on each committed cycle.
  - OUT_WAIT: out_valid=1, commit=0, pc held. Returns to RUN after out_ready=1.
  - HALT: halted=1, commit=0, pc held. Exits only via rst.
- OutR in RUN:
  - out_valid=1 in the same cycle.
  - If out_ready=1 that cycle: commit=1, pc=pc+1, stay in RUN.
  - Otherwise: commit=0, go to OUT_WAIT.
  - In OUT_WAIT, the cycle with out_ready=1 has commit=1, pc=pc+1, next state RUN.
- HLT in RUN: commit=1, pc not advanced, next state HALT.
- next_pc on commit, all sums modulo 2^PC_W:
  - Branch taken: pc+1+sext(instr[7:0]).
    - bcc is taken when flag_c=0; bcs when flag_c=1.
    - bne is taken when flag_z=0; beq when flag_z=1.
    - bal is always taken.
  - jmp, jal_label: pc+1+sext(instr[10:0]).
  - jal_rm, jr: rm_data[PC_W-1:0].
  - Untaken branch or any other instruction: pc+1.
- Link: link_we=commit & (jal_label | jal_rm). link_data={pc+1} zero-extended to 16 bits.
- Strobes are one-hot by construction. If more than one is asserted, priority is hlt > outr > jr > jal_rm > jal_label > jmp > bal > beq > bne > bcs > bcc.
- Wrap-around: pc=2^PC_W−1 with a sequential instruction gives next_pc=0. Branch offsets wrap identically.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, commit=0, link_we=0, out_valid=0, halted=0, link_data=RESET_PC+1.
- State and pc are registered.
- commit, link_we, link_data and out_valid are combinational from state, pc, the strobes and out_ready. out_valid never depends combinationally on out_ready.
- Throughput: one instruction per clock in RUN. pc changes on the rising edge after a commit cycle.
- start→first commit: start sampled high in IDLE, RUN in the next cycle, first commit in that cycle.
- out_valid, once raised, stays high with pc and instr stable until the out_ready handshake completes or rst.
- rst mid-operation (including in OUT_WAIT or HALT): next cycle state=IDLE and pc=RESET_PC; out_valid and halted drop.
- start=1 held in RUN, OUT_WAIT or HALT has no effect.

## Test plan
- Reset, then start at RESET_PC=0 with four non-control instructions -> pc sequence 0,1,2,3,4; commit=1 on every cycle after the RUN entry.
- pc=0x0010 with beq, instr[7:0]=0xFC: flag_z=1 -> next pc=0x000D; flag_z=0 -> next pc=0x0011. Repeat bcc/bcs against flag_c.
- pc=0x0020 with jal_label, instr[10:0]=0x7FF -> pc=0x0020, link_we=1, link_data=0x0021. jr with rm_data=0x1234 -> next pc=0x1234.
- outr at pc=5 with out_ready low for 3 cycles -> out_valid=1 for 4 cycles, pc=5 throughout, commit=1 only on the cycle out_ready=1, then pc=6.
- hlt at pc=9 -> commit pulse, halted=1, pc stays 9 over 10 cycles with start toggling; rst -> IDLE, pc=0.
- pc=0xFFFF with a sequential instruction -> pc=0x0000. rst asserted in OUT_WAIT -> out_valid=0 and IDLE next cycle.
